// File: rtl/monitor_regbank.sv
// rtl/monitor_regbank.sv - UART command register bank; MONITOR_REGBANK_CHECKSUM_EN adds checksum bytes
module monitor_regbank #(
  parameter int N_RW           = 5,
  parameter int N_RO           = 3,
  parameter int REG_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk50,
  input  logic                          reset_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [N_RW*8*REG_BYTES-1:0]   rw_regs,
  input  logic [N_RO*8*REG_BYTES-1:0]   ro_regs,
  output logic [N_RW-1:0]               reg_wr_stb,
  output logic                          busy,
  output logic [7:0]                    err_count
);
  localparam int         W        = 8 * REG_BYTES;
  localparam int         RO_BASE  = 128 - N_RO;
  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] NAK      = 8'h5A;
  localparam logic [7:0] N_RW_B   = 8'(N_RW);
  localparam logic [7:0] RB_B     = 8'(REG_BYTES);
  localparam logic [7:0] RO_B     = 8'(RO_BASE);
  localparam logic [31:0] TMO_MAX = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LEN, WDATA, RDATA, RESP
`ifdef MONITOR_REGBANK_CHECKSUM_EN
    , WCHK, RCHK
`endif
  } state_t;

  state_t        state, state_n;
  logic [7:0]    cmd, len, cnt, nxt_byte;
  logic [W-1:0]  wbuf, wbuf_n, wsrc, snap, rd_src;
  logic [31:0]   tmo;
  logic          resp_nak;
  logic [7:0]    id8;
  logic          wr_ok, rd_id_ok, last_byte, tx_fire, in_rx_wait, timeout, do_write;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  assign id8       = {1'b0, cmd[6:0]};
  assign wr_ok     = (id8 < N_RW_B) && (len <= RB_B);
  assign rd_id_ok  = (id8 < N_RW_B) || (id8 >= RO_B);
  assign last_byte = (cnt == len - 8'd1);
  assign tx_fire   = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
`ifdef MONITOR_REGBANK_CHECKSUM_EN
  assign in_rx_wait = (state == LEN) || (state == WDATA) || (state == WCHK);
  assign do_write   = (state == WCHK) && rx_valid && wr_ok && (rx_data == chk);
  assign wsrc       = wbuf;
`else
  assign in_rx_wait = (state == LEN) || (state == WDATA);
  assign do_write   = (state == WDATA) && rx_valid && last_byte && wr_ok;
  assign wsrc       = wbuf_n;
`endif
  assign timeout = in_rx_wait && !rx_valid && (tmo == TMO_MAX);

  // Select the register addressed by the current command for a read
  always_comb begin
    rd_src = '0;
    for (int k = 0; k < N_RW; k++)
      if (id8 == 8'(k)) rd_src = rw_regs[W*k +: W];
    for (int k = 0; k < N_RO; k++)
      if (id8 == 8'(RO_BASE + k)) rd_src = ro_regs[W*k +: W];
  end

  // Staging buffer with the incoming payload byte merged at its position
  always_comb begin
    wbuf_n = wbuf;
    for (int b = 0; b < REG_BYTES; b++)
      if (cnt == 8'(b)) wbuf_n[8*b +: 8] = rx_data;
  end

  // Next snapshot byte to present once the current one is accepted
  always_comb begin
    nxt_byte = '0;
    for (int b = 0; b < REG_BYTES; b++)
      if (cnt + 8'd1 == 8'(b)) nxt_byte = snap[8*b +: 8];
  end

  // State register
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (rx_valid) state_n = LEN;
      LEN: begin
        if (timeout) state_n = IDLE;
        else if (rx_valid) begin
          if (rx_data == 8'd0)                     state_n = RESP;
          else if (cmd[7])                         state_n = WDATA;
          else if (rd_id_ok && (rx_data <= RB_B))  state_n = RDATA;
          else                                     state_n = RESP;
        end
      end
      WDATA: begin
        if (timeout) state_n = IDLE;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
        else if (rx_valid && last_byte) state_n = WCHK;
      end
      WCHK: begin
        if (timeout) state_n = IDLE;
        else if (rx_valid) state_n = RESP;
      end
      RDATA: if (tx_fire && last_byte) state_n = RCHK;
      RCHK:  if (tx_fire) state_n = IDLE;
`else
        else if (rx_valid && last_byte) state_n = RESP;
      end
      RDATA: if (tx_fire && last_byte) state_n = IDLE;
`endif
      RESP:  if (tx_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command capture, payload staging, transmit byte sequencing, register writes and error count
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      cmd        <= '0;
      len        <= '0;
      cnt        <= '0;
      wbuf       <= '0;
      snap       <= '0;
      tmo        <= '0;
      resp_nak   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      rw_regs    <= '0;
      reg_wr_stb <= '0;
      err_count  <= '0;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      reg_wr_stb <= '0;
      if (rx_valid || !in_rx_wait) tmo <= '0;
      else                         tmo <= tmo + 32'd1;
      if (timeout && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      case (state)
        IDLE: if (rx_valid) begin
          cmd <= rx_data;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
          chk <= rx_data;
`endif
        end
        LEN: if (rx_valid) begin
          len  <= rx_data;
          cnt  <= '0;
          wbuf <= '0;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
          chk  <= chk ^ rx_data;
`endif
          if (state_n == RDATA) begin
            snap     <= rd_src;
            tx_data  <= rd_src[7:0];
            tx_valid <= 1'b1;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
            chk      <= rd_src[7:0];
`endif
          end
        end
        WDATA: if (rx_valid) begin
          wbuf <= wbuf_n;
          cnt  <= cnt + 8'd1;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
          chk  <= chk ^ rx_data;
`endif
        end
        RDATA: if (tx_fire) begin
          cnt <= cnt + 8'd1;
          if (!last_byte) begin
            tx_data <= nxt_byte;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
            chk     <= chk ^ nxt_byte;
`endif
          end else begin
`ifdef MONITOR_REGBANK_CHECKSUM_EN
            tx_data <= chk;
`else
            tx_valid <= 1'b0;
`endif
          end
        end
`ifdef MONITOR_REGBANK_CHECKSUM_EN
        RCHK: if (tx_fire) tx_valid <= 1'b0;
`endif
        RESP: if (tx_fire) begin
          tx_valid <= 1'b0;
          if (resp_nak && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
        default: ;
      endcase
      if ((state_n == RESP) && (state != RESP)) begin
        tx_valid <= 1'b1;
        tx_data  <= do_write ? ACK : NAK;
        resp_nak <= !do_write;
      end
      for (int k = 0; k < N_RW; k++) begin
        if (do_write && (id8 == 8'(k))) begin
          rw_regs[W*k +: W] <= wsrc;
          reg_wr_stb[k]     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_monitor_regbank.sv
// tb/tb_monitor_regbank.sv - self-checking bench for monitor_regbank
module tb_monitor_regbank;
  localparam int N_RW = 5;
  localparam int N_RO = 3;
  localparam int RB   = 4;
`ifdef MONITOR_REGBANK_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic                  clk50 = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'd0;
  logic                  tx_ready = 1'b1;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic [N_RW*32-1:0]    rw_regs;
  logic [N_RO*32-1:0]    ro_regs;
  logic [N_RW-1:0]       reg_wr_stb;
  logic                  busy;
  logic [7:0]            err_count;

  logic [31:0] ro_val [N_RO] = '{32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF};
  assign ro_regs = {ro_val[2], ro_val[1], ro_val[0]};

  monitor_regbank dut (
    .clk50(clk50), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rw_regs(rw_regs), .ro_regs(ro_regs), .reg_wr_stb(reg_wr_stb),
    .busy(busy), .err_count(err_count)
  );

  always #10 clk50 = ~clk50;

  int          checks = 0, failures = 0;
  logic [31:0] m_rw [N_RW];
  int          m_err = 0;
  int          exp_stb [N_RW];
  int          got_stb [N_RW];
  logic [7:0]  exp_q [$];
  logic [7:0]  tx_log [$];
  logic [7:0]  pl [$];
  logic [7:0]  lit [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  bit          slow = 0;
  int          rdy_c = 0;
  bit          hold_v = 0;
  logic [7:0]  hold_d = 8'd0;
  logic [N_RW-1:0] prev_stb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter: always ready, or ready one cycle in eleven
  initial forever begin
    @(posedge clk50); #1;
    if (slow) begin
      rdy_c = (rdy_c == 10) ? 0 : rdy_c + 1;
      tx_ready = (rdy_c == 10);
    end else tx_ready = 1'b1;
  end

  // Per-cycle compare: tx bytes vs expected stream, hold stability, strobe vs model
  initial forever begin
    @(negedge clk50);
    if (!reset_n) begin
      hold_v = 0;
      prev_stb = '0;
    end else begin
      if (tx_valid) begin
        if (hold_v) check("tx_hold_stable", tx_data, hold_d);
        if (tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
          end else check("tx_byte", tx_data, exp_q.pop_front());
          tx_log.push_back(tx_data);
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_d = tx_data;
        end
      end else if (hold_v) begin
        checks++; failures++;
        $display("FAIL tx_dropped actual=0 required=1");
        hold_v = 0;
      end
      check("txv_when_idle", tx_valid && !busy, 0);
      for (int k = 0; k < N_RW; k++) begin
        if (reg_wr_stb[k]) begin
          got_stb[k]++;
          check("stb_reg_value", rw_regs[32*k +: 32], m_rw[k]);
          check("stb_single_cycle", prev_stb[k], 0);
        end
      end
      prev_stb = reg_wr_stb;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk50); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk50); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk50);
      if (!busy) break;
      n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL wait_idle actual=busy required=idle within %0d", budget);
    end
  endtask

  task automatic model_nak();
    exp_q.push_back(8'h5A);
    if (m_err < 255) m_err++;
  endtask

  task automatic expect_read(input int idi, input int ln);
    logic [31:0] v;
    logic [7:0]  x;
    v = (idi < N_RW) ? m_rw[idi] : ro_val[idi - (128 - N_RO)];
    x = 8'd0;
    for (int i = 0; i < ln; i++) begin
      exp_q.push_back(v[8*i +: 8]);
      x = x ^ v[8*i +: 8];
    end
    if (EXTRA == 1) exp_q.push_back(x);
  endtask

  task automatic end_checks();
    for (int k = 0; k < N_RW; k++) begin
      check("rw_reg", rw_regs[32*k +: 32], m_rw[k]);
      check("stb_count", got_stb[k], exp_stb[k]);
    end
    check("err_count", err_count, m_err);
    check("tx_pending", exp_q.size(), 0);
    check("busy_end", busy, 0);
  endtask

  // Spec-level model of one command, then drive it and check the outcome
  task automatic run_cmd(input logic [7:0] c, input logic [7:0] l, input bit good_chk);
    int          idi, ln;
    logic [31:0] v;
    logic [7:0]  x;
    idi = int'(c[6:0]);
    ln  = int'(l);
    if (c[7]) begin
      if (ln != 0 && idi < N_RW && ln <= RB && (good_chk || EXTRA == 0)) begin
        v = 32'd0;
        for (int i = 0; i < ln; i++) v[8*i +: 8] = pl[i];
        m_rw[idi] = v;
        exp_stb[idi]++;
        exp_q.push_back(8'hA5);
      end else model_nak();
    end else begin
      if (ln != 0 && ln <= RB && (idi < N_RW || idi >= 128 - N_RO)) expect_read(idi, ln);
      else model_nak();
    end
    send_byte(c);
    send_byte(l);
    if (c[7] && ln != 0) begin
      x = c ^ l;
      for (int i = 0; i < ln; i++) begin
        send_byte(pl[i]);
        x = x ^ pl[i];
      end
      if (EXTRA == 1) send_byte(good_chk ? x : (x ^ 8'hFF));
    end
    wait_idle(2000);
    end_checks();
  endtask

  initial begin
    for (int k = 0; k < N_RW; k++) begin
      m_rw[k] = 32'd0; exp_stb[k] = 0; got_stb[k] = 0;
    end
    #5;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rw_regs", rw_regs, 0);
    check("rst_stb", reg_wr_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    #30 reset_n = 1'b1;

    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(8'h82, 8'h04, 1);
    check("lit_reg2", rw_regs[64 +: 32], 32'h44332211);
    check("lit_ack", tx_log[tx_log.size()-1], 8'hA5);

    pl = {};
    run_cmd(8'h7F, 8'h04, 1);
    for (int i = 0; i < 4; i++) check("lit_rd127", tx_log[tx_log.size()-4-EXTRA+i], lit[i]);
    slow = 1;
    run_cmd(8'h7F, 8'h04, 1);
    for (int i = 0; i < 4; i++) check("lit_rd127_slow", tx_log[tx_log.size()-4-EXTRA+i], lit[i]);
    slow = 0;

    pl = '{8'hAA, 8'hBB};
    run_cmd(8'h90, 8'h02, 1);
    check("lit_err_inv_wr", err_count, 8'd1);
    check("lit_nak", tx_log[tx_log.size()-1], 8'h5A);

    pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_cmd(8'h81, 8'h04, 1);
    pl = '{8'h34, 8'h12};
    run_cmd(8'h81, 8'h02, 1);
    check("lit_reg1_zero_fill", rw_regs[32 +: 32], 32'h00001234);

    pl = {};
    run_cmd(8'h83, 8'h00, 1);
    run_cmd(8'h02, 8'h00, 1);
    run_cmd(8'h02, 8'h05, 1);
    run_cmd(8'h40, 8'h01, 1);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_cmd(8'h80, 8'h05, 1);
    pl = {};
    run_cmd(8'h02, 8'h02, 1);
    run_cmd(8'h7D, 8'h01, 1);
    check("lit_ro_idx0", tx_log[tx_log.size()-1], 8'h67);

    slow = 1;
    expect_read(2, 4);
    send_byte(8'h02);
    send_byte(8'h04);
    repeat (3) @(posedge clk50);
    send_byte(8'h82);
    wait_idle(2000);
    end_checks();
    slow = 0;

    send_byte(8'h81);
    send_byte(8'h04);
    send_byte(8'h01);
    repeat (49990) @(posedge clk50);
    #1 check("tmo_still_busy", busy, 1);
    repeat (30) @(posedge clk50);
    #1 check("tmo_idle", busy, 0);
    if (m_err < 255) m_err++;
    end_checks();

`ifdef MONITOR_REGBANK_CHECKSUM_EN
    pl = '{8'h5A};
    run_cmd(8'h80, 8'h01, 1);
    check("lit_chk_reg0", rw_regs[0 +: 32], 32'h0000005A);
    pl = '{8'h77};
    run_cmd(8'h80, 8'h01, 0);
    check("lit_chk_bad_reg0", rw_regs[0 +: 32], 32'h0000005A);
`endif

    pl = {};
    for (int i = 0; i < 250; i++) run_cmd(8'h00, 8'h00, 1);
    check("lit_err_saturated", err_count, 8'hFF);

    slow = 1;
    expect_read(127, 4);
    send_byte(8'h7F);
    send_byte(8'h04);
    repeat (15) @(posedge clk50);
    #5 check("mid_rdata_txv", tx_valid, 1);
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_rw_regs", rw_regs, 0);
    check("arst_stb", reg_wr_stb, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_count, 0);
    exp_q = {};
    m_err = 0;
    for (int k = 0; k < N_RW; k++) begin
      m_rw[k] = 32'd0; exp_stb[k] = 0; got_stb[k] = 0;
    end
    slow = 0;
    repeat (3) @(posedge clk50);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk50);
    check("post_rst_no_tx", tx_valid, 0);

    pl = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    run_cmd(8'h84, 8'h04, 1);
    pl = {};
    run_cmd(8'h04, 8'h03, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
